aukv_uart_rx: RTL and testbench



---
 rtl/aukv_uart_pkg.sv | 21 ++
 rtl/aukv_sync_fifo.sv | 51 +++++
 rtl/aukv_uart_rx.sv | 196 +++++++++++++++++++
 tb/tb_aukv_uart_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aukv_uart_pkg.sv
// Shared UART definitions for the AUK-V RX (and the future TX) datapath.
// Frame FSM encoding, data width, default bit timing and a 3-input vote helper.
package aukv_uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/aukv_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module aukv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == FULL_CNT);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);
  assign o_dout  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_din;
  end

endmodule

// File: rtl/aukv_uart_rx.sv
// AUK-V UART receiver: 2-flop synchroniser, mid-bit 3-sample vote, FWFT byte FIFO.
// Define AUKV_UART_RX_PARITY_EN for 8E1 frames with a sticky o_parity_err output.
module aukv_uart_rx
  import aukv_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clr_err,
`ifdef AUKV_UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] S_LO   = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] S_MID  = CW'(CLKS_PER_BIT/2);
  localparam logic [CW-1:0] S_HI   = CW'(CLKS_PER_BIT/2 + 1);
  localparam logic [CW-1:0] S_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rxs, rxs_d;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 s_lo_q, s_mid_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 at_hi, maj;
  logic                 shift_en, idx_clr, push, set_ferr, set_ovr, par_bad;
  logic                 ferr_q, ovr_q;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [7:0]           fifo_dout;
`ifdef AUKV_UART_RX_PARITY_EN
  logic                 set_perr, perr_q, par_bad_q;
`endif

  assign rxs   = sync_q[1];
  assign at_hi = (cnt_q == S_HI);
  // The third vote is taken live on the mid+1 cycle, so decisions land there.
  assign maj   = maj3(s_lo_q, s_mid_q, rxs);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    push     = 1'b0;
    set_ferr = 1'b0;
    set_ovr  = 1'b0;
`ifdef AUKV_UART_RX_PARITY_EN
    set_perr = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (rxs_d & ~rxs) state_d = ST_START;
      ST_START: begin
        if (at_hi) begin
          if (maj) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_clr = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (at_hi) begin
          shift_en = 1'b1;
          if (idx_q == I_LAST) begin
`ifdef AUKV_UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef AUKV_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (at_hi) begin
          state_d  = ST_STOP;
          set_perr = (maj != ^shreg_q);
        end
      end
`endif
      ST_STOP: begin
        if (at_hi) begin
          if (maj) begin
            // Leave at mid+1 so a start bit right after the stop bit is caught.
            state_d = ST_IDLE;
            if (!par_bad) begin
              if (fifo_full && !fifo_pop) set_ovr = 1'b1;
              else                        push    = 1'b1;
            end
          end else begin
            state_d  = ST_BREAK;
            set_ferr = 1'b1;
          end
        end
      end
      ST_BREAK: if (rxs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      rxs_d   <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      s_lo_q  <= 1'b1;
      s_mid_q <= 1'b1;
      shreg_q <= '0;
    end else begin
      sync_q <= {sync_q[0], i_rx};
      rxs_d  <= rxs;
      // Held at zero in IDLE so START begins counting from the detected edge.
      if (state_q == ST_IDLE || cnt_q == S_LAST) cnt_q <= '0;
      else                                       cnt_q <= cnt_q + 1'b1;
      if (cnt_q == S_LO)  s_lo_q  <= rxs;
      if (cnt_q == S_MID) s_mid_q <= rxs;
      if (idx_clr)       idx_q <= '0;
      else if (shift_en) idx_q <= idx_q + 1'b1;
      if (shift_en) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
    end
  end

  // Set beats clear when both happen in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (set_ferr)       ferr_q <= 1'b1;
      else if (i_clr_err) ferr_q <= 1'b0;
      if (set_ovr)        ovr_q  <= 1'b1;
      else if (i_clr_err) ovr_q  <= 1'b0;
    end
  end

`ifdef AUKV_UART_RX_PARITY_EN
  // par_bad_q remembers a bad parity bit for this frame independent of i_clr_err.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      if (set_perr)       perr_q <= 1'b1;
      else if (i_clr_err) perr_q <= 1'b0;
      if (state_q == ST_IDLE) par_bad_q <= 1'b0;
      else if (set_perr)      par_bad_q <= 1'b1;
    end
  end
  assign par_bad      = par_bad_q;
  assign o_parity_err = perr_q;
`else
  assign par_bad = 1'b0;
`endif

  aukv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_din   (shreg_q),
    .i_pop   (fifo_pop),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_rx_valid  = ~fifo_empty;
  assign fifo_pop    = o_rx_valid & i_rx_ready;
  assign o_rx_data   = o_rx_valid ? fifo_dout : 8'h00;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aukv_uart_rx.sv
// Directed + randomized bench for aukv_uart_rx against a queue-based byte model.
`timescale 1ns/1ps
module tb_aukv_uart_rx;

  localparam int C = 16;
  localparam int D = 4;
  // Edges from start-bit launch to o_rx_valid: 2 sync + 1 edge detect,
  // 9 full bit periods, mid+1 into the stop bit, then the FIFO push edge.
  localparam int LAT = 3 + 9*C + (C/2 + 1) + 1;

  logic       i_clk = 1'b0;
  logic       i_rst, i_rx, i_rx_ready, i_clr_err;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, o_frame_err, o_overrun, o_busy;
`ifdef AUKV_UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int checks = 0;
  int failures = 0;
  int npops = 0;
  logic [7:0] model[$];
  logic exp_ferr = 1'b0;
  logic exp_ovr = 1'b0;
  bit rnd_rdy = 1'b0;

  always #5 i_clk = ~i_clk;

  aukv_uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .i_rx_ready  (i_rx_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .i_clr_err   (i_clr_err),
`ifdef AUKV_UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_busy      (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the oldest byte the model holds.
  always @(negedge i_clk) begin
    if (!i_rst && o_rx_valid && i_rx_ready) begin
      npops++;
      check("pop_model_nonempty", 32'(model.size() > 0), 32'd1);
      if (model.size() > 0) check("pop_data", {24'd0, o_rx_data}, {24'd0, model.pop_front()});
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
      i_rx = 1'b1;
      if (rnd_rdy) i_rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clr_pulse();
    @(posedge i_clk); #1; i_clr_err = 1'b1;
    @(posedge i_clk); #1; i_clr_err = 1'b0;
  endtask

  // Drives one 10-bit frame, one bit per C edges; optional latency check,
  // single-cycle pop on edge pop_at, or a one-cycle reset at edge rst_at.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_at,
                            input int pop_at, input bit chk_lat);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int e = 0; e < 10*C; e++) begin
      @(posedge i_clk); #1;
      if (rst_at >= 0 && e == rst_at + 1) begin
        i_rst = 1'b0;
        check("rst_valid", 32'(o_rx_valid), 32'd0);
        check("rst_data",  {24'd0, o_rx_data}, 32'd0);
        check("rst_busy",  32'(o_busy), 32'd0);
        check("rst_ferr",  32'(o_frame_err), 32'd0);
        check("rst_ovr",   32'(o_overrun), 32'd0);
        model.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        i_rx = 1'b1;
        return;
      end
      i_rx = fr[e / C];
      if (e == rst_at) i_rst = 1'b1;
      if (rnd_rdy) i_rx_ready = 1'($urandom_range(0, 1));
      if (e == pop_at) i_rx_ready = 1'b1;
      if (pop_at >= 0 && e == pop_at + 1) i_rx_ready = 1'b0;
      if (chk_lat && e == LAT - 1) check("lat_before", 32'(o_rx_valid), 32'd0);
      if (chk_lat && e == LAT) begin
        check("lat_valid", 32'(o_rx_valid), 32'd1);
        check("lat_data", {24'd0, o_rx_data}, {24'd0, b});
      end
      if (e == LAT) begin
        if (!stop)                  exp_ferr = 1'b1;
        else if (model.size() < D)  model.push_back(b);
        else                        exp_ovr = 1'b1;
      end
    end
  endtask

  initial begin
    int p0;
    logic [7:0] rb;
    logic st;
    i_rst = 1'b1; i_rx = 1'b1; i_rx_ready = 1'b0; i_clr_err = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_valid", 32'(o_rx_valid), 32'd0);
    check("reset_data",  {24'd0, o_rx_data}, 32'd0);
    check("reset_ferr",  32'(o_frame_err), 32'd0);
    check("reset_ovr",   32'(o_overrun), 32'd0);
    check("reset_busy",  32'(o_busy), 32'd0);
    i_rst = 1'b0;
    idle(2*C);

    // Single frame, held until ready.
    send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
    idle(3*C);
    check("hold_valid", 32'(o_rx_valid), 32'd1);
    check("hold_data",  {24'd0, o_rx_data}, 32'hA5);
    p0 = npops;
    i_rx_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rx_ready = 1'b0;
    check("single_pops", 32'(npops - p0), 32'd1);
    check("single_empty", 32'(o_rx_valid), 32'd0);

    // Back-to-back frames with no idle gap.
    p0 = npops;
    i_rx_ready = 1'b1;
    send_frame(8'h00, 1'b1, -1, -1, 1'b0);
    send_frame(8'hFF, 1'b1, -1, -1, 1'b0);
    send_frame(8'h5A, 1'b1, -1, -1, 1'b0);
    idle(2*C);
    check("b2b_pops", 32'(npops - p0), 32'd3);
    check("b2b_ferr", 32'(o_frame_err), 32'd0);
    check("b2b_ovr",  32'(o_overrun), 32'd0);

    // Start-bit glitch of two cycles.
    p0 = npops;
    @(posedge i_clk); #1; i_rx = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1; i_rx = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("glitch_busy", 32'(o_busy), 32'd1);
    idle(2*C);
    check("glitch_idle",  32'(o_busy), 32'd0);
    check("glitch_valid", 32'(o_rx_valid), 32'd0);
    check("glitch_pops",  32'(npops - p0), 32'd0);
    check("glitch_ferr",  32'(o_frame_err), 32'd0);

    // Framing error: stop bit low, then line high.
    i_rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0, -1, -1, 1'b0);
    idle(C);
    check("frame_err",   32'(o_frame_err), 32'(exp_ferr));
    check("frame_valid", 32'(o_rx_valid), 32'd0);
    check("frame_busy",  32'(o_busy), 32'd0);
    clr_pulse();
    exp_ferr = 1'b0;
    check("frame_clr", 32'(o_frame_err), 32'd0);

    // Overrun: five bytes into a four-deep FIFO.
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, -1, -1, 1'b0);
    idle(C);
    check("ovr_flag", 32'(o_overrun), 32'(exp_ovr));
    check("ovr_head", {24'd0, o_rx_data}, 32'h01);
    clr_pulse();
    exp_ovr = 1'b0;
    check("ovr_clr", 32'(o_overrun), 32'd0);
    // Sixth byte lands while full, with a pop on the same cycle.
    p0 = npops;
    send_frame(8'h06, 1'b1, -1, LAT - 1, 1'b0);
    idle(C);
    check("fullpop_pops", 32'(npops - p0), 32'd1);
    check("fullpop_ovr",  32'(o_overrun), 32'(exp_ovr));
    i_rx_ready = 1'b1;
    idle(8);
    check("fullpop_drain", 32'(model.size()), 32'd0);

    // Reset during data bit 3, with a byte already buffered.
    i_rx_ready = 1'b0;
    send_frame(8'($urandom), 1'b1, -1, -1, 1'b0);
    send_frame(8'($urandom), 1'b1, 4*C + C/2, -1, 1'b0);
    idle(2*C);
    p0 = npops;
    i_rx_ready = 1'b1;
    send_frame(8'h81, 1'b1, -1, -1, 1'b1);
    idle(C);
    check("post_rst_pops", 32'(npops - p0), 32'd1);

    // Randomized bytes, stop bits, gaps and ready pattern.
    clr_pulse();
    rnd_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(rb, st, -1, -1, 1'b0);
      idle(st ? $urandom_range(0, C) : C);
    end
    rnd_rdy = 1'b0;
    i_rx_ready = 1'b0;
    idle(2);
    check("rand_ferr", 32'(o_frame_err), 32'(exp_ferr));
    check("rand_ovr",  32'(o_overrun), 32'(exp_ovr));
    i_rx_ready = 1'b1;
    idle(8);
    check("rand_drain", 32'(model.size()), 32'd0);
    check("rand_empty", 32'(o_rx_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
